// File: rtl/gshare_predictor_pkg.sv
// Shared constants and helpers for the gshare/bimodal branch predictor.
// Holds the truth constants, counter reset value, index/tag sizing and saturating counter math.
package gshare_predictor_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int              WORD_W    = 32;
    localparam logic [WORD_W-1:0] ZERO_WORD = '0;

    // Widest counter the helpers support; counters are zero-extended into this width.
    localparam int CNT_MAX_W = 16;

    // Number of index bits for a power-of-two table depth.
    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

    // Tag bits left over once the byte offset [1:0] and the index are removed.
    function automatic int tag_w(input int addr_w, input int depth);
        return addr_w - $clog2(depth) - 2;
    endfunction

    // Weakly-taken reset value: only the MSB set.
    function automatic logic [CNT_MAX_W-1:0] cnt_reset(input int cnt_w);
        return CNT_MAX_W'(1) << (cnt_w - 1);
    endfunction

    // Saturating step: up towards 2^cnt_w-1, down towards 0.
    function automatic logic [CNT_MAX_W-1:0] sat_update(
        input logic [CNT_MAX_W-1:0] cnt,
        input logic                 up,
        input int                   cnt_w
    );
        logic [CNT_MAX_W-1:0] cnt_max;
        cnt_max = (CNT_MAX_W'(1) << cnt_w) - CNT_MAX_W'(1);
        if (up) begin
            return (cnt == cnt_max) ? cnt : cnt + CNT_MAX_W'(1);
        end
        return (cnt == '0) ? cnt : cnt - CNT_MAX_W'(1);
    endfunction

endpackage

// File: rtl/pred_btb.sv
// Tagged branch target buffer: one combinational read port, one write port.
// Valid bits clear asynchronously; tag and target storage is never reset.
module pred_btb
    import gshare_predictor_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_pc,
    output logic              rd_hit,
    output logic [ADDR_W-1:0] rd_tar,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_pc,
    input  logic [ADDR_W-1:0] wr_tar
);

    localparam int IDX_W = idx_w(ENTRIES);
    localparam int TAG_W = tag_w(ADDR_W, ENTRIES);

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [ADDR_W-1:0]  tar_q [ENTRIES];

    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;

    assign rd_idx = rd_pc[IDX_W+1:2];
    assign rd_tag = rd_pc[ADDR_W-1:IDX_W+2];
    assign wr_idx = wr_pc[IDX_W+1:2];
    assign wr_tag = wr_pc[ADDR_W-1:IDX_W+2];

    // Instructions are word aligned, so the byte offset never reaches the tables.
    logic unused_offset;
    assign unused_offset = ^{rd_pc[1:0], wr_pc[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= TRUE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx] <= wr_tag;
            tar_q[wr_idx] <= wr_tar;
        end
    end

    assign rd_hit = valid_q[rd_idx] ? (tag_q[rd_idx] == rd_tag) : FALSE;
    assign rd_tar = tar_q[rd_idx];

endmodule

// File: rtl/gshare_predictor.sv
// IF-stage branch predictor: BTB plus a PHT of saturating counters, gshare-indexed.
// Define PRED_GSHARE_EN to XOR the PHT index with a speculative global history; otherwise bimodal.
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int BTB_ENTRIES = 64,
    parameter int PHT_ENTRIES = 256,
    parameter int CNT_W       = 2,
    parameter int GHR_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic              if_fire,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_tar_o,
    output logic [GHR_W-1:0]  pred_ghr_o,
    // ex_valid is a one-cycle request with no back-pressure: it is consumed on any
    // rising edge where rdy=1 and dropped (not stored) when rdy=0, so EX holds it until rdy.
    input  logic              ex_valid,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic              ex_taken,
    input  logic [ADDR_W-1:0] ex_tar,
    input  logic [GHR_W-1:0]  ex_ghr,
    input  logic              ex_mispredict
);

    localparam int               PHT_IDX_W = idx_w(PHT_ENTRIES);
    localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(cnt_reset(CNT_W));

    logic                 train_en;
    logic                 btb_hit;
    logic [ADDR_W-1:0]    btb_tar;
    logic [GHR_W-1:0]     ghr;
    logic [GHR_W-1:0]     train_hist;
    logic [PHT_IDX_W-1:0] look_idx;
    logic [PHT_IDX_W-1:0] train_idx;
    logic [CNT_W-1:0]     pht_q [PHT_ENTRIES];

    assign train_en = rdy & ex_valid;

    pred_btb #(
        .ADDR_W  (ADDR_W),
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk    (clk),
        .rst_n  (rst_n),
        .rd_pc  (if_pc),
        .rd_hit (btb_hit),
        .rd_tar (btb_tar),
        .wr_en  (train_en),
        .wr_pc  (ex_pc),
        .wr_tar (ex_tar)
    );

`ifdef PRED_GSHARE_EN
    logic [GHR_W-1:0] ghr_q;

    // A mispredict rebuilds history from the EX snapshot and overrides any same-cycle fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q <= '0;
        end else if (rdy) begin
            if (ex_valid && ex_mispredict) begin
                ghr_q <= (ex_ghr << 1) | GHR_W'(ex_taken);
            end else if (if_fire) begin
                ghr_q <= (ghr_q << 1) | GHR_W'(pred_taken_o);
            end
        end
    end

    assign ghr        = ghr_q;
    assign train_hist = ex_ghr;
`else
    assign ghr        = '0;
    assign train_hist = '0;

    logic unused_hist;
    assign unused_hist = ^{ex_ghr, if_fire, ex_mispredict};
`endif

    assign look_idx  = if_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr);
    assign train_idx = ex_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(train_hist);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht_q[i] <= CNT_INIT;
            end
        end else if (train_en) begin
            pht_q[train_idx] <= CNT_W'(sat_update(CNT_MAX_W'(pht_q[train_idx]), ex_taken, CNT_W));
        end
    end

    // Reads see pre-edge state; a same-cycle training write is not forwarded.
    assign pred_taken_o = rdy & btb_hit & pht_q[look_idx][CNT_W-1];
    assign pred_tar_o   = pred_taken_o ? btb_tar : ADDR_W'(ZERO_WORD);
    assign pred_ghr_o   = rdy ? ghr : '0;

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor with hand-computed expectations.
// History expectations follow PRED_GSHARE_EN as seen by this file.
module tb_gshare_predictor;

`ifdef PRED_GSHARE_EN
    localparam bit GSHARE = 1'b1;
`else
    localparam bit GSHARE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rdy = 1'b1;
    logic [31:0] if_pc = '0;
    logic        if_fire = 1'b0;
    logic        pred_taken_o;
    logic [31:0] pred_tar_o;
    logic [7:0]  pred_ghr_o;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = '0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_tar = '0;
    logic [7:0]  ex_ghr = '0;
    logic        ex_mispredict = 1'b0;

    int n_assert = 0;
    int n_fail = 0;

    gshare_predictor dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rdy           (rdy),
        .if_pc         (if_pc),
        .if_fire       (if_fire),
        .pred_taken_o  (pred_taken_o),
        .pred_tar_o    (pred_tar_o),
        .pred_ghr_o    (pred_ghr_o),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_taken      (ex_taken),
        .ex_tar        (ex_tar),
        .ex_ghr        (ex_ghr),
        .ex_mispredict (ex_mispredict)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid      = 1'b0;
        if_fire       = 1'b0;
        ex_mispredict = 1'b0;
    endtask

    task automatic train(input logic [31:0] pc, input logic taken,
                         input logic [31:0] tar, input logic [7:0] hist);
        ex_valid = 1'b1;
        ex_pc    = pc;
        ex_taken = taken;
        ex_tar   = tar;
        ex_ghr   = hist;
        tick();
        ex_valid = 1'b0;
    endtask

    // checking
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_pred(input string tag, input logic [31:0] pc, input logic exp_taken,
                              input logic [31:0] exp_tar, input logic [7:0] exp_ghr);
        if_pc = pc;
        #1;
        chk({tag, ".taken"}, 32'(pred_taken_o), 32'(exp_taken));
        chk({tag, ".tar"}, pred_tar_o, exp_tar);
        chk({tag, ".ghr"}, 32'(pred_ghr_o), 32'(exp_ghr));
    endtask

    function automatic logic [7:0] gh(input logic [7:0] v);
        return GSHARE ? v : 8'h00;
    endfunction

    initial begin
        // reset
        #1 rst_n = 1'b0;
        check_pred("rst_hold", 32'h100, 1'b0, 32'h0, 8'h00);
        tick();
        tick();
        rst_n = 1'b1;
        check_pred("rst_rel", 32'h100, 1'b0, 32'h0, 8'h00);
        tick();

        // train 0x100 taken; same-cycle lookup sees the old (empty) entry
        ex_valid = 1'b1;
        ex_pc    = 32'h100;
        ex_taken = 1'b1;
        ex_tar   = 32'h200;
        ex_ghr   = 8'h00;
        check_pred("no_bypass", 32'h100, 1'b0, 32'h0, 8'h00);
        tick();
        ex_valid = 1'b0;
        check_pred("train_hit", 32'h100, 1'b1, 32'h200, 8'h00);
        check_pred("alias", 32'h1100, 1'b0, 32'h0, 8'h00);
        tick();

        // saturation on counter for 0x100 (now 3)
        train(32'h100, 1'b0, 32'h200, 8'h00);
        check_pred("sat_nt1", 32'h100, 1'b1, 32'h200, 8'h00);
        train(32'h100, 1'b0, 32'h200, 8'h00);
        check_pred("sat_nt2", 32'h100, 1'b0, 32'h0, 8'h00);
        train(32'h100, 1'b0, 32'h200, 8'h00);
        train(32'h100, 1'b0, 32'h200, 8'h00);
        check_pred("sat_nt4", 32'h100, 1'b0, 32'h0, 8'h00);
        train(32'h100, 1'b0, 32'h200, 8'h00);
        check_pred("sat_floor", 32'h100, 1'b0, 32'h0, 8'h00);
        train(32'h100, 1'b1, 32'h200, 8'h00);
        check_pred("sat_up1", 32'h100, 1'b0, 32'h0, 8'h00);
        train(32'h100, 1'b1, 32'h200, 8'h00);
        check_pred("sat_up2", 32'h100, 1'b1, 32'h200, 8'h00);
        train(32'h100, 1'b1, 32'h200, 8'h00);
        train(32'h100, 1'b1, 32'h200, 8'h00);
        train(32'h100, 1'b0, 32'h200, 8'h00);
        check_pred("sat_ceiling", 32'h100, 1'b1, 32'h200, 8'h00);
        tick();

        // history: three taken fires, then mispredict recovery in a fire cycle
        if_fire = 1'b1;
        check_pred("fire0", 32'h100, 1'b1, 32'h200, 8'h00);
        tick();
        check_pred("fire1", 32'h100, 1'b1, 32'h200, gh(8'h01));
        tick();
        check_pred("fire2", 32'h100, 1'b1, 32'h200, gh(8'h03));
        tick();
        ex_valid      = 1'b1;
        ex_mispredict = 1'b1;
        ex_pc         = 32'h104;
        ex_taken      = 1'b0;
        ex_tar        = 32'h400;
        ex_ghr        = 8'h05;
        check_pred("fire3", 32'h100, 1'b1, 32'h200, gh(8'h07));
        tick();
        idle();
        check_pred("recover", 32'h1100, 1'b0, 32'h0, gh(8'h0A));
        tick();

        // fire on a predicted-not-taken lookup shifts in 0
        if_fire = 1'b1;
        if_pc   = 32'h1100;
        tick();
        idle();
        check_pred("fire_nt", 32'h1100, 1'b0, 32'h0, gh(8'h14));
        tick();

        // mispredict without ex_valid must not touch history
        ex_mispredict = 1'b1;
        ex_ghr        = 8'hFF;
        ex_taken      = 1'b1;
        tick();
        idle();
        check_pred("mp_novalid", 32'h1100, 1'b0, 32'h0, gh(8'h14));
        tick();

        // training under history 0x03 hits a different counter only in gshare mode
        train(32'h100, 1'b0, 32'h200, 8'h03);
        train(32'h100, 1'b0, 32'h200, 8'h03);
        check_pred("hist_idx", 32'h100, GSHARE, GSHARE ? 32'h200 : 32'h0, gh(8'h14));
        tick();

        // rdy gating
        rdy      = 1'b0;
        ex_valid = 1'b1;
        ex_pc    = 32'h208;
        ex_taken = 1'b1;
        ex_tar   = 32'h500;
        ex_ghr   = 8'h00;
        if_fire  = 1'b1;
        check_pred("rdy0", 32'h100, 1'b0, 32'h0, 8'h00);
        tick();
        rdy = 1'b1;
        idle();
        check_pred("rdy_miss", 32'h208, 1'b0, 32'h0, gh(8'h14));
        tick();
        train(32'h208, 1'b1, 32'h500, 8'h00);
        check_pred("rdy1_train", 32'h208, 1'b1, 32'h500, gh(8'h14));
        tick();

        // drive 0x100's history-0 counter to 0, then reset mid-training
        train(32'h100, 1'b0, 32'h200, 8'h00);
        train(32'h100, 1'b0, 32'h200, 8'h00);
        ex_valid = 1'b1;
        ex_pc    = 32'h100;
        ex_taken = 1'b1;
        ex_tar   = 32'h200;
        ex_ghr   = 8'h00;
        #2 rst_n = 1'b0;
        check_pred("rst_mid", 32'h100, 1'b0, 32'h0, 8'h00);
        tick();
        ex_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        check_pred("rst_mid_rel", 32'h100, 1'b0, 32'h0, 8'h00);
        tick();
        train(32'h100, 1'b1, 32'h200, 8'h00);
        check_pred("rst_pht_init", 32'h100, 1'b1, 32'h200, 8'h00);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
